// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared constants, state encoding and store-lane helpers for the MEM-stage sequencer
package mem_access_pkg;

    localparam logic [1:0] MASK_BYTE = 2'b00;
    localparam logic [1:0] MASK_HALF = 2'b01;
    localparam logic [1:0] MASK_WORD = 2'b10;

    localparam logic [3:0] STRB_BYTE = 4'b0001;
    localparam logic [3:0] STRB_HALF = 4'b0011;
    localparam logic [3:0] STRB_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    // mask[1] set means word, so the reserved encoding 2'b11 also behaves as a word
    function automatic logic [3:0] store_strobe(input logic [1:0] mask, input logic [1:0] offset);
        if (mask[1])
            return STRB_WORD;
        else if (mask[0])
            return STRB_HALF << {offset[1], 1'b0};
        else
            return STRB_BYTE << offset;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] mask, input logic [31:0] wdata);
        if (mask[1])
            return wdata;
        else if (mask[0])
            return {2{wdata[15:0]}};
        else
            return {4{wdata[7:0]}};
    endfunction

endpackage

// File: rtl/load_lane_extract.sv
// rtl/load_lane_extract.sv - selects the addressed load lane and sign/zero-extends it to a full word
module load_lane_extract
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  mask,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[7:0];
        case (offset)
            2'd0: byte_lane = rdata[7:0];
            2'd1: byte_lane = rdata[15:8];
            2'd2: byte_lane = rdata[23:16];
            2'd3: byte_lane = rdata[31:24];
            default: byte_lane = rdata[7:0];
        endcase
        half_lane = offset[1] ? rdata[31:16] : rdata[15:0];

        if (mask[1])
            data = rdata;
        else if (mask[0])
            data = {{16{~is_unsigned & half_lane[15]}}, half_lane};
        else
            data = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
    end

endmodule

// File: rtl/mem_access_controller.sv
// rtl/mem_access_controller.sv - MEM-stage load/store sequencer with req/ack memory handshake
// Optional REQ timeout abort is built when MEM_TIMEOUT_EN is defined.
module mem_access_controller
    import mem_access_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 32,
    parameter int NB_MASK = 2,
    parameter int NB_STRB = 4
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic               i_read,
    input  logic               i_write,
    input  logic [NB_ADDR-1:0] i_addr,
    input  logic [NB_MASK-1:0] i_mascara,
    input  logic               i_is_unsigned,
    input  logic [NB_DATA-1:0] i_wdata,
    output logic               o_stall,
    output logic               o_done,
    output logic [NB_DATA-1:0] o_rdata,
    output logic               o_addr_error,
    output logic               o_bus_error,
    output logic               o_mem_req,
    output logic               o_mem_we,
    output logic [NB_ADDR-1:0] o_mem_addr,
    output logic [NB_STRB-1:0] o_mem_wstrb,
    output logic [NB_DATA-1:0] o_mem_wdata,
    input  logic               i_mem_ack,
    input  logic [NB_DATA-1:0] i_mem_rdata
);

    state_t             state, state_nxt;
    logic               accept;
    logic               illegal;
    logic               timeout_hit;
    logic [1:0]         lat_mask;
    logic [1:0]         lat_offset;
    logic               lat_unsigned;
    logic [NB_DATA-1:0] load_data;

    assign accept = i_valid & (i_read | i_write);

    always_comb begin
        illegal = i_read & i_write;
        if (i_mascara[1])
            illegal = illegal | (i_addr[1:0] != 2'b00);
        else if (i_mascara[0])
            illegal = illegal | i_addr[0];
    end

`ifdef MEM_TIMEOUT_EN
    logic [7:0] req_cnt;

    // counter idles at zero outside REQ, so it is clear on every REQ entry
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset)
            req_cnt <= 8'd0;
        else if (state != ST_REQ)
            req_cnt <= 8'd0;
        else if (!i_mem_ack)
            req_cnt <= req_cnt + 8'd1;
    end

    assign timeout_hit = (state == ST_REQ) && !i_mem_ack && (req_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = illegal ? ST_ERR : ST_REQ;
            ST_REQ: begin
                if (i_mem_ack)
                    state_nxt = ST_DONE;
                else if (timeout_hit)
                    state_nxt = ST_IDLE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            ST_ERR:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    load_lane_extract u_extract (
        .rdata       (i_mem_rdata),
        .offset      (lat_offset),
        .mask        (lat_mask),
        .is_unsigned (lat_unsigned),
        .data        (load_data)
    );

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_mem_addr   <= '0;
            o_mem_we     <= 1'b0;
            o_mem_wstrb  <= '0;
            o_mem_wdata  <= '0;
            o_rdata      <= '0;
            o_bus_error  <= 1'b0;
            lat_mask     <= 2'b00;
            lat_offset   <= 2'b00;
            lat_unsigned <= 1'b0;
        end else begin
            o_bus_error <= timeout_hit;
            if (state == ST_IDLE && accept && !illegal) begin
                o_mem_addr   <= {i_addr[NB_ADDR-1:2], 2'b00};
                o_mem_we     <= i_write;
                o_mem_wstrb  <= i_write ? store_strobe(i_mascara, i_addr[1:0]) : '0;
                o_mem_wdata  <= store_lanes(i_mascara, i_wdata);
                lat_mask     <= i_mascara;
                lat_offset   <= i_addr[1:0];
                lat_unsigned <= i_is_unsigned;
            end
            if (state == ST_REQ && i_mem_ack)
                o_rdata <= load_data;
        end
    end

    assign o_mem_req    = (state == ST_REQ);
    assign o_done       = (state == ST_DONE);
    assign o_addr_error = (state == ST_ERR);
    // the accept term is combinational on i_valid, so mask it while reset is held
    assign o_stall      = i_reset & (((state == ST_IDLE) & accept) | (state == ST_REQ));

endmodule

// File: tb/tb_mem_access_controller.sv
// tb/tb_mem_access_controller.sv - self-checking bench for mem_access_controller with a behavioural access model
module tb_mem_access_controller;

    logic        i_clock;
    logic        i_reset;
    logic        i_valid;
    logic        i_read;
    logic        i_write;
    logic [31:0] i_addr;
    logic [1:0]  i_mascara;
    logic        i_is_unsigned;
    logic [31:0] i_wdata;
    logic        o_stall;
    logic        o_done;
    logic [31:0] o_rdata;
    logic        o_addr_error;
    logic        o_bus_error;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [3:0]  o_mem_wstrb;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;

    int checks = 0;
    int errors = 0;

    mem_access_controller dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_valid       (i_valid),
        .i_read        (i_read),
        .i_write       (i_write),
        .i_addr        (i_addr),
        .i_mascara     (i_mascara),
        .i_is_unsigned (i_is_unsigned),
        .i_wdata       (i_wdata),
        .o_stall       (o_stall),
        .o_done        (o_done),
        .o_rdata       (o_rdata),
        .o_addr_error  (o_addr_error),
        .o_bus_error   (o_bus_error),
        .o_mem_req     (o_mem_req),
        .o_mem_we      (o_mem_we),
        .o_mem_addr    (o_mem_addr),
        .o_mem_wstrb   (o_mem_wstrb),
        .o_mem_wdata   (o_mem_wdata),
        .i_mem_ack     (i_mem_ack),
        .i_mem_rdata   (i_mem_rdata)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    // One access from the pipeline, acked on the k-th REQ cycle; expectations come from size/offset arithmetic.
    task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr, input logic [1:0] mask,
                              input logic uns, input logic [31:0] wd, input int k, input logic [31:0] mrd,
                              input string name);
        int          size;
        logic        active;
        logic        legal;
        logic [3:0]  e_strb;
        logic [31:0] e_wd;
        logic [31:0] e_rd;
        logic [31:0] lane;
        active = rd | wr;
        size   = mask[1] ? 4 : (mask[0] ? 2 : 1);
        legal  = !(rd && wr) && ((addr % size) == 0);
        if (!wr)            e_strb = 4'h0;
        else if (size == 4) e_strb = 4'hF;
        else if (size == 2) e_strb = 4'h3 << (addr & 2);
        else                e_strb = 4'h1 << (addr % 4);
        if (size == 4)      e_wd = wd;
        else if (size == 2) e_wd = (wd & 32'hFFFF) * 32'h0001_0001;
        else                e_wd = (wd & 32'hFF) * 32'h0101_0101;
        lane = mrd >> (8 * (addr % 4));
        if (size == 4) e_rd = mrd;
        else if (size == 2) begin
            e_rd = lane & 32'hFFFF;
            if (!uns && e_rd >= 32'h8000) e_rd = e_rd + 32'hFFFF_0000;
        end else begin
            e_rd = lane & 32'hFF;
            if (!uns && e_rd >= 32'h80) e_rd = e_rd + 32'hFFFF_FF00;
        end

        i_valid = 1'b1; i_read = rd; i_write = wr; i_addr = addr;
        i_mascara = mask; i_is_unsigned = uns; i_wdata = wd;
        #1;
        checks++;
        if (o_stall !== active) begin
            errors++; $display("FAIL %s accept_stall got %b want %b", name, o_stall, active);
        end
        tick();
        i_valid = 1'b0; i_read = 1'b0; i_write = 1'b0;
        i_wdata = $urandom; i_addr = $urandom; i_mascara = 2'($urandom); i_is_unsigned = 1'($urandom);

        if (!active) begin
            checks++;
            if (o_mem_req !== 1'b0 || o_stall !== 1'b0 || o_addr_error !== 1'b0) begin
                errors++; $display("FAIL %s ignored req=%b stall=%b aerr=%b want 0 0 0", name, o_mem_req, o_stall, o_addr_error);
            end
            return;
        end
        if (!legal) begin
            checks++;
            if (o_addr_error !== 1'b1 || o_mem_req !== 1'b0 || o_stall !== 1'b0) begin
                errors++; $display("FAIL %s addr_error aerr=%b req=%b stall=%b want 1 0 0", name, o_addr_error, o_mem_req, o_stall);
            end
            tick();
            checks++;
            if (o_addr_error !== 1'b0 || o_mem_req !== 1'b0) begin
                errors++; $display("FAIL %s addr_error_pulse aerr=%b req=%b want 0 0", name, o_addr_error, o_mem_req);
            end
            return;
        end

        for (int c = 1; c <= k; c++) begin
            checks++;
            if (o_mem_req !== 1'b1 || o_stall !== 1'b1 || o_bus_error !== 1'b0) begin
                errors++; $display("FAIL %s req_cycle%0d req=%b stall=%b berr=%b want 1 1 0", name, c, o_mem_req, o_stall, o_bus_error);
            end
            checks++;
            if (o_mem_addr !== (addr & 32'hFFFF_FFFC) || o_mem_we !== wr || o_mem_wstrb !== e_strb) begin
                errors++; $display("FAIL %s req_fields addr=%h we=%b strb=%b want %h %b %b", name, o_mem_addr, o_mem_we, o_mem_wstrb, addr & 32'hFFFF_FFFC, wr, e_strb);
            end
            if (wr) begin
                checks++;
                if (o_mem_wdata !== e_wd) begin
                    errors++; $display("FAIL %s wdata got %h want %h", name, o_mem_wdata, e_wd);
                end
            end
            i_mem_ack   = (c == k);
            i_mem_rdata = (c == k) ? mrd : $urandom;
            tick();
        end
        i_mem_ack = 1'b0;
        i_mem_rdata = $urandom;

        checks++;
        if (o_done !== 1'b1 || o_mem_req !== 1'b0 || o_stall !== 1'b0 || o_bus_error !== 1'b0) begin
            errors++; $display("FAIL %s done done=%b req=%b stall=%b berr=%b want 1 0 0 0", name, o_done, o_mem_req, o_stall, o_bus_error);
        end
        if (rd) begin
            checks++;
            if (o_rdata !== e_rd) begin
                errors++; $display("FAIL %s rdata got %h want %h", name, o_rdata, e_rd);
            end
        end
        tick();
        checks++;
        if (o_done !== 1'b0) begin
            errors++; $display("FAIL %s done_pulse got %b want 0", name, o_done);
        end
        if (rd) begin
            checks++;
            if (o_rdata !== e_rd) begin
                errors++; $display("FAIL %s rdata_hold got %h want %h", name, o_rdata, e_rd);
            end
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b0; i_valid = 1'b1; i_read = 1'b1; i_write = 1'b0;
        i_addr = 32'h100; i_mascara = 2'b10; i_is_unsigned = 1'b0; i_wdata = 32'h0;
        i_mem_ack = 1'b0; i_mem_rdata = 32'h0;
        repeat (3) tick();
        checks++;
        if ({o_stall, o_done, o_addr_error, o_bus_error, o_mem_req, o_mem_we} !== 6'b0 ||
            o_rdata !== 32'h0 || o_mem_addr !== 32'h0 || o_mem_wstrb !== 4'h0 || o_mem_wdata !== 32'h0) begin
            errors++; $display("FAIL reset_outputs ctl=%b rdata=%h addr=%h strb=%b wdata=%h want all 0",
                               {o_stall, o_done, o_addr_error, o_bus_error, o_mem_req, o_mem_we},
                               o_rdata, o_mem_addr, o_mem_wstrb, o_mem_wdata);
        end
        i_valid = 1'b0; i_read = 1'b0;
        i_reset = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        run_access(1, 0, 32'h100, 2'b10, 0, 32'h0, 3, 32'hDEADBEEF, "lw_0x100");
        run_access(1, 0, 32'h103, 2'b00, 0, 32'h0, 1, 32'h80123456, "lb_0x103");
        run_access(1, 0, 32'h103, 2'b00, 1, 32'h0, 2, 32'h80123456, "lbu_0x103");
        run_access(1, 0, 32'h102, 2'b01, 0, 32'h0, 1, 32'h80123456, "lh_0x102");
        run_access(0, 1, 32'h101, 2'b00, 0, 32'h000000AB, 1, 32'h0, "sb_0x101");
        run_access(0, 1, 32'h102, 2'b01, 0, 32'h00001234, 2, 32'h0, "sh_0x102");
        run_access(1, 0, 32'h102, 2'b10, 0, 32'h0, 1, 32'h0, "lw_misaligned");
        run_access(0, 1, 32'h101, 2'b01, 0, 32'h0, 1, 32'h0, "sh_misaligned");
        run_access(1, 1, 32'h100, 2'b10, 0, 32'h0, 1, 32'h0, "read_and_write");
        run_access(0, 0, 32'h100, 2'b10, 0, 32'h0, 1, 32'h0, "valid_no_op");
        run_access(1, 0, 32'h204, 2'b11, 0, 32'h0, 1, 32'hCAFEF00D, "mask11_word");
    endtask

    task automatic test_latency();
        int t_accept;
        int t_done;
        int cyc;
        bit seen;
        i_valid = 1'b1; i_read = 1'b1; i_write = 1'b0; i_addr = 32'h100; i_mascara = 2'b10;
        cyc = 0; t_accept = 0; t_done = -1; seen = 0;
        tick();
        i_valid = 1'b0; i_read = 1'b0;
        for (int c = 1; c <= 8 && !seen; c++) begin
            i_mem_ack = (c == 1); i_mem_rdata = 32'h1234_5678;
            tick();
            i_mem_ack = 1'b0;
            if (o_done === 1'b1) begin seen = 1; t_done = c + 1; end
        end
        cyc = t_done - t_accept;
        checks++;
        if (cyc !== 2) begin
            errors++; $display("FAIL min_latency got %0d want 2", cyc);
        end
        tick();
    endtask

    task automatic test_reset_during_req();
        i_valid = 1'b1; i_read = 1'b1; i_write = 1'b0; i_addr = 32'h100; i_mascara = 2'b10;
        tick();
        i_valid = 1'b0; i_read = 1'b0;
        tick();
        checks++;
        if (o_mem_req !== 1'b1) begin
            errors++; $display("FAIL pre_reset_req got %b want 1", o_mem_req);
        end
        #2 i_reset = 1'b0;
        #1;
        checks++;
        if (o_mem_req !== 1'b0 || o_stall !== 1'b0) begin
            errors++; $display("FAIL async_reset req=%b stall=%b want 0 0", o_mem_req, o_stall);
        end
        tick();
        i_reset = 1'b1;
        tick();
        checks++;
        if (o_mem_req !== 1'b0 || o_done !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle req=%b done=%b want 0 0", o_mem_req, o_done);
        end
        run_access(1, 0, 32'h100, 2'b10, 0, 32'h0, 2, 32'h0BAD_F00D, "lw_after_reset");
    endtask

    task automatic test_random();
        logic        rd, wr;
        int          r;
        for (int n = 0; n < 60; n++) begin
            r = int'($urandom_range(0, 9));
            rd = (r == 0) || (r >= 2 && r < 6);
            wr = (r == 0) || (r >= 6);
            run_access(rd, wr, 32'h1000 + 32'($urandom_range(0, 255)), 2'($urandom_range(0, 3)),
                       1'($urandom), $urandom, int'($urandom_range(1, 4)), $urandom, "random");
        end
    endtask

    task automatic test_timeout();
`ifdef MEM_TIMEOUT_EN
        i_valid = 1'b1; i_read = 1'b1; i_write = 1'b0; i_addr = 32'h100; i_mascara = 2'b10;
        tick();
        i_valid = 1'b0; i_read = 1'b0;
        for (int c = 1; c <= 255; c++) begin
            checks++;
            if (o_mem_req !== 1'b1 || o_bus_error !== 1'b0) begin
                errors++; $display("FAIL timeout_wait%0d req=%b berr=%b want 1 0", c, o_mem_req, o_bus_error);
            end
            tick();
        end
        checks++;
        if (o_bus_error !== 1'b1 || o_mem_req !== 1'b0 || o_done !== 1'b0 || o_stall !== 1'b0) begin
            errors++; $display("FAIL timeout_abort berr=%b req=%b done=%b stall=%b want 1 0 0 0", o_bus_error, o_mem_req, o_done, o_stall);
        end
        tick();
        checks++;
        if (o_bus_error !== 1'b0) begin
            errors++; $display("FAIL timeout_pulse got %b want 0", o_bus_error);
        end
        run_access(1, 0, 32'h100, 2'b10, 0, 32'h0, 255, 32'h5555_AAAA, "ack_on_expiry");
`else
        run_access(1, 0, 32'h100, 2'b10, 0, 32'h0, 300, 32'h5555_AAAA, "no_timeout_wait");
`endif
    endtask

    initial begin
        test_reset();
        test_directed();
        test_latency();
        test_reset_during_req();
        test_random();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout simulation did not complete");
        $fatal(1);
    end

endmodule
